// File: rtl/block_ram_fifo_pkg.sv
// rtl/block_ram_fifo_pkg.sv - shared width constants and log2 helper for the block RAM FIFO
package block_ram_fifo_pkg;

  // count carries ram_count plus up to two output-stage words and one in-flight read
  localparam int COUNT_EXTRA_BITS = 2;

  // head register plus one skid register
  localparam int OUT_STAGE_SLOTS = 2;

  // Number of bits needed to represent value (minimum 1)
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/block_ram_fifo_ram.sv
// rtl/block_ram_fifo_ram.sv - true dual-port block RAM with registered reads on both ports
module dual_port_block_ram
  import block_ram_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int LOG2_DEPTH = log2(DEPTH - 1)
) (
  input  logic                  clk,
  input  logic                  wr_a,
  input  logic [LOG2_DEPTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      d_a,
  output logic [WIDTH-1:0]      q_a,
  input  logic                  wr_b,
  input  logic [LOG2_DEPTH-1:0] addr_b,
  input  logic [WIDTH-1:0]      d_b,
  output logic [WIDTH-1:0]      q_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: writes land at the edge, reads return the pre-edge contents one cycle later
  always_ff @(posedge clk) begin
    if (wr_a) mem[addr_a] <= d_a;
    if (wr_b) mem[addr_b] <= d_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/block_ram_fifo.sv
// rtl/block_ram_fifo.sv - block RAM FIFO with registered read and a two-entry output stage
module block_ram_fifo
  import block_ram_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int LOG2_DEPTH = log2(DEPTH - 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [WIDTH-1:0]                     d,
  output logic                                 full,
  output logic                                 overflow,
  output logic [WIDTH-1:0]                     q,
  output logic                                 q_valid,
  input  logic                                 q_ready,
  output logic [LOG2_DEPTH+COUNT_EXTRA_BITS-1:0] count
);

  localparam int CW = LOG2_DEPTH + COUNT_EXTRA_BITS;
  localparam int RW = LOG2_DEPTH + 1;
  localparam logic [RW-1:0]         RAM_FULL = RW'(DEPTH);
  localparam logic [LOG2_DEPTH-1:0] PTR_LAST = LOG2_DEPTH'(DEPTH - 1);

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]         ram_count_q, ram_count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  q_valid_q, q_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic [WIDTH-1:0]      skid_q, skid_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  push, pop, issue;
  logic [1:0]            stage_occ, stage_after_pop;
  logic [WIDTH-1:0]      ram_q_b;
  logic [WIDTH-1:0]      ram_q_a_unused;

  function automatic logic [LOG2_DEPTH-1:0] ptr_inc(input logic [LOG2_DEPTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Port A takes pushes, port B reads the next committed entry
  dual_port_block_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_a   (push),
    .addr_a (wr_ptr_q),
    .d_a    (d),
    .q_a    (ram_q_a_unused),
    .wr_b   (1'b0),
    .addr_b (rd_ptr_q),
    .d_b    ('0),
    .q_b    (ram_q_b)
  );

  // Next-state: pointers, RAM occupancy, read issue and output-stage moves
  always_comb begin
    push            = wr_en & ~full_q;
    pop             = q_valid_q & q_ready;
    stage_occ       = {1'b0, q_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
    stage_after_pop = stage_occ - {1'b0, pop};
    // ram_count excludes this cycle's push, so rd_ptr never meets an in-progress write
    issue           = (ram_count_q != '0) && (stage_after_pop < 2'd2);

    wr_ptr_d    = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_count_d = ram_count_q + RW'(push) - RW'(issue);
    rd_pend_d   = issue;

    head_d       = head_q;
    skid_d       = skid_q;
    q_valid_d    = q_valid_q;
    skid_valid_d = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        head_d = skid_q;
        if (rd_pend_q) skid_d = ram_q_b;
        else           skid_valid_d = 1'b0;
      end else if (rd_pend_q) begin
        head_d = ram_q_b;
      end else begin
        q_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      if (!q_valid_q) begin
        head_d    = ram_q_b;
        q_valid_d = 1'b1;
      end else begin
        skid_d       = ram_q_b;
        skid_valid_d = 1'b1;
      end
    end

    full_d     = (ram_count_d == RAM_FULL);
    overflow_d = wr_en & full_q;
    count_d    = CW'(ram_count_d) + CW'(rd_pend_d) + CW'(q_valid_d) + CW'(skid_valid_d);
  end

  // State registers; reset drops all held words but leaves RAM contents alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pend_q    <= 1'b0;
      q_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pend_q    <= rd_pend_d;
      q_valid_q    <= q_valid_d;
      skid_valid_q <= skid_valid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      count_q      <= count_d;
    end
  end

  assign q        = head_q;
  assign q_valid  = q_valid_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_block_ram_fifo.sv
// tb/tb_block_ram_fifo.sv - self-checking bench for block_ram_fifo (WIDTH=8, DEPTH=4)
module tb_block_ram_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] d;
  logic             full;
  logic             overflow;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic [3:0]       count;

  block_ram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .d        (d),
    .full     (full),
    .overflow (overflow),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: three FIFOs of words (RAM, in-flight read, output stage)
  logic [WIDTH-1:0] m_ram[$];
  logic [WIDTH-1:0] m_fly[$];
  logic [WIDTH-1:0] m_out[$];
  bit               m_ov;
  int               m_pushes;
  bit               model_on = 0;

  task automatic model_clear();
    m_ram.delete(); m_fly.delete(); m_out.delete();
    m_ov = 0;
  endtask

  task automatic model_step(input bit w, input logic [WIDTH-1:0] dd, input bit rdy);
    bit was_full, pop, push, issue;
    was_full = (m_ram.size() == DEPTH);
    pop      = (m_out.size() > 0) && rdy;
    push     = w && !was_full;
    issue    = (m_ram.size() > 0) && ((m_out.size() + m_fly.size() - int'(pop)) < 2);
    if (pop) void'(m_out.pop_front());
    if (m_fly.size() > 0) m_out.push_back(m_fly.pop_front());
    if (issue) m_fly.push_back(m_ram.pop_front());
    if (push) begin
      m_ram.push_back(dd);
      m_pushes++;
    end
    m_ov = w && was_full;
  endtask

  task automatic model_check();
    chk("m_q_valid", int'(q_valid), int'(m_out.size() > 0));
    if (m_out.size() > 0) chk("m_q", int'(q), int'(m_out[0]));
    chk("m_full", int'(full), int'(m_ram.size() == DEPTH));
    chk("m_overflow", int'(overflow), int'(m_ov));
    chk("m_count", int'(count), m_ram.size() + m_fly.size() + m_out.size());
  endtask

  // One clock: drive inputs, clock, then sample 1 time unit after the edge
  task automatic cycle(input bit w, input logic [WIDTH-1:0] dd, input bit rdy);
    bit               stall;
    logic [WIDTH-1:0] held;
    wr_en   = w;
    d       = dd;
    q_ready = rdy;
    stall   = q_valid && !rdy;
    held    = q;
    if (model_on) model_step(w, dd, rdy);
    @(posedge clk);
    #1;
    if (model_on) model_check();
    if (stall) begin
      chk("q_stable_valid", int'(q_valid), 1);
      chk("q_stable", int'(q), int'(held));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_q_valid", int'(q_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit               wr;
    logic [WIDTH-1:0] d;
    bit               rdy;
    bit               ev;
    logic [WIDTH-1:0] eq;
    bit               ef;
    bit               eo;
    int               ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit wr, logic [WIDTH-1:0] dd, bit rdy,
                              bit ev, logic [WIDTH-1:0] eq, bit ef, bit eo, int ec);
    vec_t v;
    v.wr = wr; v.d = dd; v.rdy = rdy;
    v.ev = ev; v.eq = eq; v.ef = ef; v.eo = eo; v.ec = ec;
    tbl.push_back(v);
  endfunction

  initial begin
    int cyc;
    rst = 1'b1; wr_en = 1'b0; d = '0; q_ready = 1'b0;
    m_pushes = 0;
    model_clear();

    // Single push of 0xA5 with q_ready=1: visible three cycles later, then popped
    add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
    add(0, 8'h00, 1, 1, 8'hA5, 0, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    // Fill with q_ready=0: two in the output stage, four in RAM, seventh push overflows
    add(1, 8'h01, 0, 0, 8'h00, 0, 0, 1);
    add(1, 8'h02, 0, 0, 8'h00, 0, 0, 2);
    add(1, 8'h03, 0, 1, 8'h01, 0, 0, 3);
    add(1, 8'h04, 0, 1, 8'h01, 0, 0, 4);
    add(1, 8'h05, 0, 1, 8'h01, 0, 0, 5);
    add(1, 8'h06, 0, 1, 8'h01, 1, 0, 6);
    add(1, 8'h07, 0, 1, 8'h01, 1, 1, 6);
    add(0, 8'h00, 0, 1, 8'h01, 1, 0, 6);
    // Push while full coinciding with a pop and read issue: push dropped, overflow pulses
    add(1, 8'h08, 1, 1, 8'h02, 0, 1, 5);
    // Drain in order, one word per cycle
    add(0, 8'h00, 1, 1, 8'h03, 0, 0, 4);
    add(0, 8'h00, 1, 1, 8'h04, 0, 0, 3);
    add(0, 8'h00, 1, 1, 8'h05, 0, 0, 2);
    add(0, 8'h00, 1, 1, 8'h06, 0, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

    // Reset state while rst is held
    @(posedge clk); @(posedge clk);
    #1;
    chk("init_count", int'(count), 0);
    chk("init_q_valid", int'(q_valid), 0);
    chk("init_q", int'(q), 0);
    chk("init_full", int'(full), 0);
    chk("init_overflow", int'(overflow), 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_q_valid", i), int'(q_valid), int'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_q", i), int'(q), int'(tbl[i].eq));
      chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].ef));
      chk($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].eo));
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].ec);
    end

    // Continuous push/pop of 0x00..0x1F across several pointer wraps
    pulse_reset();
    model_on = 1;
    for (int i = 0; i < 32; i++) cycle(1'b1, WIDTH'(i), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("stream_drained", m_ram.size() + m_fly.size() + m_out.size(), 0);

    // Random push/ready traffic until 200 accepted pushes, then drain
    m_pushes = 0;
    cyc = 0;
    while (m_pushes < 200 && cyc < 3000) begin
      cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), $urandom_range(0, 1) == 1);
      cyc++;
    end
    chk("rand_push_budget", int'(m_pushes >= 200), 1);
    cyc = 0;
    while ((m_ram.size() + m_fly.size() + m_out.size()) > 0 && cyc < 50) begin
      cycle(1'b0, '0, 1'b1);
      cyc++;
    end
    chk("rand_drain_budget", m_ram.size() + m_fly.size() + m_out.size(), 0);

    // Reset mid-operation with three words held, then a fresh push of 0x3C
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("held_count", int'(count), 3);
    pulse_reset();
    cycle(1'b1, 8'h3C, 1'b0);
    chk("post_rst_e1_q_valid", int'(q_valid), 0);
    cycle(1'b0, '0, 1'b0);
    chk("post_rst_e2_q_valid", int'(q_valid), 0);
    cycle(1'b0, '0, 1'b0);
    chk("post_rst_e3_q_valid", int'(q_valid), 1);
    chk("post_rst_e3_q", int'(q), 'h3C);
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_count", int'(count), 0);
    model_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
